// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - MSB-first serial-to-parallel receiver with a one-word valid/ready holding register.
// Define DESER_PARITY_EN to append one even-parity bit per frame and report it on parity_err.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             parity_err,
  output logic             busy
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam int SW    = WIDTH;
`else
  localparam int FRAME = WIDTH;
  localparam int SW    = WIDTH - 1;
`endif
  localparam int CW = $clog2(FRAME + 1);

  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_shift;
  logic [WIDTH-1:0] r_word_out;
  logic             r_word_valid;
  logic             r_overflow;
  logic             r_parity_err;

  logic             w_last;
  logic             w_complete;
  logic             w_drain;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;
  logic [SW-1:0]    w_shift_next;

  assign w_last     = (r_count == CW'(FRAME - 1));
  assign w_complete = bit_valid && w_last;
  assign w_drain    = r_word_valid && word_ready;
  // A completed frame may land in the holding register when it is free or emptying this edge.
  assign w_load     = w_complete && (!r_word_valid || word_ready);

`ifdef DESER_PARITY_EN
  typedef enum logic {S_COLLECT, S_PARITY} state_t;
  state_t r_state;

  assign w_word       = r_shift;
  assign w_perr       = (^r_shift) ^ bit_in;
  assign w_shift_next = {r_shift[WIDTH-2:0], bit_in};
`else
  // The final bit goes straight into the word, so the shifter only keeps WIDTH-1 bits.
  assign w_word       = {r_shift, bit_in};
  assign w_perr       = 1'b0;
  assign w_shift_next = w_word[WIDTH-2:0];
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count      <= '0;
      r_shift      <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef DESER_PARITY_EN
      r_state      <= S_COLLECT;
`endif
    end else if (clr) begin
      r_count      <= '0;
      r_shift      <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef DESER_PARITY_EN
      r_state      <= S_COLLECT;
`endif
    end else begin
      if (bit_valid) begin
        r_count <= w_last ? '0 : r_count + 1'b1;
`ifdef DESER_PARITY_EN
        if (r_state == S_COLLECT) begin
          r_shift <= w_shift_next;
          if (r_count == CW'(WIDTH - 1))
            r_state <= S_PARITY;
        end else begin
          r_state <= S_COLLECT;
        end
`else
        r_shift <= w_shift_next;
`endif
      end
      if (w_load) begin
        r_word_out   <= w_word;
        r_word_valid <= 1'b1;
        r_parity_err <= w_perr;
      end else begin
        if (w_complete)
          r_overflow <= 1'b1;
        if (w_drain)
          r_word_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;
  assign busy       = (r_count != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - directed table-driven bench for serial_deserializer (WIDTH=8).
module tb_serial_deserializer;

`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready = 1'b0;
  logic       overflow;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad = 0;

  serial_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .clr        (clr),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_clr;
    logic [7:0] d;
    bit         gap;
    logic       rdy;
    logic [7:0] e_out;
    logic       e_valid;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] e_out, input logic e_valid,
                           input logic e_ovf, input logic e_perr, input logic e_busy);
    chk({name, ".word_out"}, 32'(word_out), 32'(e_out));
    chk({name, ".word_valid"}, 32'(word_valid), 32'(e_valid));
    chk({name, ".overflow"}, 32'(overflow), 32'(e_ovf));
    chk({name, ".parity_err"}, 32'(parity_err), 32'(e_perr));
    chk({name, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_state("clr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends one frame MSB-first; rdy_last is the word_ready seen on the frame's final edge.
  task automatic send(input logic [7:0] d, input bit gap, input logic rdy,
                      input logic rdy_last, input bit flip);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bit_valid  = 1'b1;
      bit_in     = d[i];
      word_ready = (i == 0 && !PAR) ? rdy_last : rdy;
      if (gap && !(i == 0 && !PAR)) begin
        @(negedge clk);
        bit_valid = 1'b0;
        chk("busy_gap", 32'(busy), 32'd1);
      end
    end
    if (PAR) begin
      @(negedge clk);
      bit_valid  = 1'b1;
      bit_in     = (^d) ^ flip;
      word_ready = rdy_last;
    end
    @(negedge clk);
    bit_valid  = 1'b0;
    word_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hB2, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h5A, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].do_clr) do_clr();
      send(tbl[v].d, tbl[v].gap, tbl[v].rdy, tbl[v].rdy, 1'b0);
      chk_state($sformatf("vec%0d", v), tbl[v].e_out, tbl[v].e_valid, tbl[v].e_ovf, 1'b0, 1'b0);
    end

    // One-cycle drain: valid drops, overflow stays sticky, word_out holds.
    @(negedge clk);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    chk_state("drain", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);

    // Completion on the same edge that drains the held word.
    do_clr();
    send(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_state("drain_and_load", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush mid-word with clr racing a valid bit.
    send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_before_flush", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
    end
    @(negedge clk);
    bit_valid = 1'b1;
    chk("busy_before_clr", 32'(busy), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    bit_valid = 1'b0;
    chk_state("clr_midword", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("after_clr", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    // Same again with the asynchronous reset as the flush.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = 1'b1;
    end
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b     = 1'b1;
    bit_valid = 1'b0;
    chk_state("rst_midword", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("after_rst", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef DESER_PARITY_EN
    do_clr();
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = tbl[0].d[i];
    end
    @(negedge clk);
    bit_valid = 1'b0;
    chk("par_no_valid_at_8", 32'(word_valid), 32'd0);
    chk("par_busy_at_8", 32'(busy), 32'd1);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    @(negedge clk);
    bit_valid = 1'b0;
    chk_state("par_good", 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0);
    do_clr();
    send(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_state("par_bad", 8'hB2, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
